rangedecode: RTL and testbench



---
 rtl/busdecode_pkg.sv | 20 ++
 rtl/decode_skid.sv | 76 +++++++
 rtl/rangedecode.sv | 124 ++++++++++++
 tb/tb_rangedecode.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/busdecode_pkg.sv
// Shared helpers for bus address decoders: one-hot generation, default slave
// count and inclusive range matching.
package busdecode_pkg;

  localparam int unsigned BUSDECODE_NS = 4;
  localparam int unsigned MAX_AW       = 64;
  localparam int unsigned MAX_ONEHOT   = 64;

  function automatic logic [MAX_ONEHOT-1:0] onehot(input int unsigned idx);
    return MAX_ONEHOT'(1) << idx;
  endfunction

  // Callers zero-extend AW-bit operands, so the compare stays unsigned with no wrap.
  function automatic logic range_match(input logic [MAX_AW-1:0] addr,
                                       input logic [MAX_AW-1:0] base,
                                       input logic [MAX_AW-1:0] last);
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry registered skid buffer; both o_valid and o_stall come straight from flops.
module decode_skid #(
  parameter int unsigned W            = 8,
  parameter bit          OPT_LOWPOWER = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_stall,
  input  logic [W-1:0] i_payload,
  output logic         o_valid,
  input  logic         i_stall,
  output logic [W-1:0] o_payload
);

  // State bits are {out_valid, skid_valid}.
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b10;
  localparam logic [1:0] StFull  = 2'b11;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (i_valid) begin
          out_d   = i_payload;
          state_d = StOne;
        end
      end
      StOne: begin
        if (!i_stall) begin
          if (i_valid) begin
            out_d = i_payload;
          end else begin
            state_d = StEmpty;
            if (OPT_LOWPOWER) out_d = '0;
          end
        end else if (i_valid) begin
          skid_d  = i_payload;
          state_d = StFull;
        end
      end
      StFull: begin
        if (!i_stall) begin
          out_d   = skid_q;
          state_d = StOne;
          if (OPT_LOWPOWER) skid_d = '0;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign o_valid   = state_q[1];
  assign o_stall   = state_q[0];
  assign o_payload = out_q;

endmodule

// File: rtl/rangedecode.sv
// Pipelined base/last range decoder with fixed-priority resolution and a skid output stage.
// Optional error log enabled by defining RANGEDECODE_ERRLOG_EN.
module rangedecode
  import busdecode_pkg::*;
#(
  parameter int unsigned      NS             = BUSDECODE_NS,
  parameter int unsigned      AW             = 32,
  parameter int unsigned      DW             = 38,
  parameter logic [NS*AW-1:0] SLAVE_BASE     = '0,
  parameter logic [NS*AW-1:0] SLAVE_LAST     = '0,
  parameter logic [NS-1:0]    ACCESS_ALLOWED = '1,
  parameter bit               OPT_LOWPOWER   = 1'b0,
  parameter int unsigned      ERRCW          = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_stall,
  input  logic [AW-1:0]    i_addr,
  input  logic [DW-1:0]    i_data,
  output logic             o_valid,
  input  logic             i_stall,
  output logic [NS:0]      o_decode,
  output logic [AW-1:0]    o_addr,
  output logic [DW-1:0]    o_data,
  input  logic             i_err_clear,
  output logic [ERRCW-1:0] o_err_count,
  output logic             o_err_valid,
  output logic [AW-1:0]    o_err_addr
);

  localparam int unsigned ERR_IDX = NS;
  localparam int unsigned PW      = NS + 1 + AW + DW;

  logic                  found;
  int unsigned           winner;
  logic [MAX_ONEHOT-1:0] win_hot;
  logic [MAX_ONEHOT-1:0] hot;
  logic [NS:0]           in_decode;
  logic [PW-1:0]         out_payload;

  // Scan from highest index down so the lowest-index match wins; a denied winner
  // goes to the error slot rather than falling through.
  always_comb begin
    found  = 1'b0;
    winner = 0;
    for (int k = int'(NS) - 1; k >= 0; k--) begin
      if (range_match(MAX_AW'(i_addr), MAX_AW'(SLAVE_BASE[k*AW +: AW]),
                      MAX_AW'(SLAVE_LAST[k*AW +: AW]))) begin
        found  = 1'b1;
        winner = unsigned'(k);
      end
    end
    win_hot   = onehot(winner);
    hot       = (found && |(ACCESS_ALLOWED & win_hot[NS-1:0])) ? win_hot : onehot(ERR_IDX);
    in_decode = hot[NS:0];
  end

  decode_skid #(
    .W           (PW),
    .OPT_LOWPOWER(OPT_LOWPOWER)
  ) u_skid (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_stall  (o_stall),
    .i_payload({in_decode, i_addr, i_data}),
    .o_valid  (o_valid),
    .i_stall  (i_stall),
    .o_payload(out_payload)
  );

  assign {o_decode, o_addr, o_data} = out_payload;

`ifdef RANGEDECODE_ERRLOG_EN
  logic             err_evt;
  logic [ERRCW-1:0] err_count_q, err_count_d;
  logic             err_valid_q, err_valid_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;

  assign err_evt = o_valid && !i_stall && o_decode[ERR_IDX];

  // A clear that coincides with an error restarts the log with that error.
  always_comb begin
    err_count_d = err_count_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (i_err_clear) begin
      err_count_d = err_evt ? ERRCW'(1) : '0;
      err_valid_d = err_evt;
      err_addr_d  = err_evt ? o_addr : '0;
    end else if (err_evt) begin
      if (err_count_q != '1) err_count_d = err_count_q + ERRCW'(1);
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        err_addr_d  = o_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign o_err_count = err_count_q;
  assign o_err_valid = err_valid_q;
  assign o_err_addr  = err_addr_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = i_err_clear;
  assign o_err_count      = '0;
  assign o_err_valid      = 1'b0;
  assign o_err_addr       = '0;
`endif

endmodule

// File: tb/tb_rangedecode.sv
// Directed self-checking bench for rangedecode (3 slaves, ERRCW=2, low-power outputs).
module tb_rangedecode;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 38;
  localparam int unsigned ERRCW = 2;
`ifdef RANGEDECODE_ERRLOG_EN
  localparam bit ErrLogEn = 1'b1;
`else
  localparam bit ErrLogEn = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             o_stall;
  logic [AW-1:0]    in_addr;
  logic [DW-1:0]    in_data;
  logic             o_valid;
  logic             in_stall;
  logic [NS:0]      o_decode;
  logic [AW-1:0]    o_addr;
  logic [DW-1:0]    o_data;
  logic             err_clear;
  logic [ERRCW-1:0] o_err_count;
  logic             o_err_valid;
  logic [AW-1:0]    o_err_addr;

  int vectors;
  int miscompares;

  rangedecode #(
    .NS            (NS),
    .AW            (AW),
    .DW            (DW),
    .SLAVE_BASE    ({32'h8000_0000, 32'h1000_0000, 32'h1000_0000}),
    .SLAVE_LAST    ({32'h8000_FFFF, 32'h1FFF_FFFF, 32'h1000_0FFF}),
    .ACCESS_ALLOWED(3'b011),
    .OPT_LOWPOWER  (1'b1),
    .ERRCW         (ERRCW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_valid    (in_valid),
    .o_stall    (o_stall),
    .i_addr     (in_addr),
    .i_data     (in_data),
    .o_valid    (o_valid),
    .i_stall    (in_stall),
    .o_decode   (o_decode),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .i_err_clear(err_clear),
    .o_err_count(o_err_count),
    .o_err_valid(o_err_valid),
    .o_err_addr (o_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_stall = 1'b0; err_clear = 1'b0;
    in_addr = '0; in_data = '0;
    repeat (2) tick();
    reset = 1'b0;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h want 0", o_valid); end
    vectors++; if (o_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0h want 0", o_stall); end
    vectors++; if (o_decode !== 4'b0000) begin miscompares++; $display("FAIL reset_decode got %b want 0000", o_decode); end
    vectors++; if (o_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", o_addr); end
    vectors++; if (o_err_count !== 2'd0) begin miscompares++; $display("FAIL reset_err_count got %0d want 0", o_err_count); end
    vectors++; if (o_err_valid !== 1'b0) begin miscompares++; $display("FAIL reset_err_valid got %0h want 0", o_err_valid); end
    vectors++; if (o_err_addr !== 32'h0) begin miscompares++; $display("FAIL reset_err_addr got %h want 0", o_err_addr); end
  endtask

  task automatic test_decode;
    logic [31:0] addrs [8];
    logic [3:0]  decs  [8];
    logic [37:0] d;
    addrs = '{32'h1000_0800, 32'h1000_1000, 32'h1FFF_FFFF, 32'h2000_0000,
              32'h1000_0000, 32'h0FFF_FFFF, 32'h8000_FFFF, 32'h8001_0000};
    decs  = '{4'b0001, 4'b0010, 4'b0010, 4'b1000,
              4'b0001, 4'b1000, 4'b1000, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      d = {6'(i + 1), addrs[i]};
      in_valid = 1'b1; in_addr = addrs[i]; in_data = d;
      tick();
      in_valid = 1'b0;
      vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL decode_valid[%0d] got %0h want 1", i, o_valid); end
      vectors++; if (o_decode !== decs[i]) begin miscompares++; $display("FAIL decode[%0d] addr %h got %b want %b", i, addrs[i], o_decode, decs[i]); end
      vectors++; if (o_data !== d) begin miscompares++; $display("FAIL decode_data[%0d] got %h want %h", i, o_data, d); end
      tick();
      vectors++; if ({o_valid, o_decode, o_addr} !== 37'h0) begin miscompares++; $display("FAIL decode_lowpower[%0d] got v=%0h dec=%b a=%h want all 0", i, o_valid, o_decode, o_addr); end
    end
    // Four errors drained: count saturates at 3, first one captured.
    vectors++; if (o_err_count !== (ErrLogEn ? 2'd3 : 2'd0)) begin miscompares++; $display("FAIL decode_err_count got %0d want %0d", o_err_count, ErrLogEn ? 3 : 0); end
    vectors++; if (o_err_addr !== (ErrLogEn ? 32'h2000_0000 : 32'h0)) begin miscompares++; $display("FAIL decode_err_addr got %h want %h", o_err_addr, ErrLogEn ? 32'h2000_0000 : 32'h0); end
  endtask

  task automatic test_access_denied;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if ({o_err_valid, o_err_count, o_err_addr} !== 35'h0) begin miscompares++; $display("FAIL clear_only got v=%0h c=%0d a=%h want all 0", o_err_valid, o_err_count, o_err_addr); end
    in_valid = 1'b1; in_addr = 32'h8000_0004; in_data = 38'h15_8000_0004;
    tick();
    in_valid = 1'b0;
    vectors++; if (o_decode !== 4'b1000) begin miscompares++; $display("FAIL denied_decode got %b want 1000", o_decode); end
    tick();
    vectors++; if (o_err_count !== (ErrLogEn ? 2'd1 : 2'd0)) begin miscompares++; $display("FAIL denied_err_count got %0d want %0d", o_err_count, ErrLogEn ? 1 : 0); end
    vectors++; if (o_err_addr !== (ErrLogEn ? 32'h8000_0004 : 32'h0)) begin miscompares++; $display("FAIL denied_err_addr got %h want %h", o_err_addr, ErrLogEn ? 32'h8000_0004 : 32'h0); end
    vectors++; if (o_err_valid !== ErrLogEn) begin miscompares++; $display("FAIL denied_err_valid got %0h want %0h", o_err_valid, ErrLogEn); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 32'h9000_0000 + 32'(i); in_data = 38'(i);
      tick();
      vectors++; if ({o_valid, o_decode} !== 5'b11000) begin miscompares++; $display("FAIL sat_decode[%0d] got v=%0h dec=%b want 1/1000", i, o_valid, o_decode); end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (o_err_count !== (ErrLogEn ? 2'd3 : 2'd0)) begin miscompares++; $display("FAIL sat_err_count got %0d want %0d", o_err_count, ErrLogEn ? 3 : 0); end
    vectors++; if (o_err_addr !== (ErrLogEn ? 32'h8000_0004 : 32'h0)) begin miscompares++; $display("FAIL sat_err_addr got %h want %h", o_err_addr, ErrLogEn ? 32'h8000_0004 : 32'h0); end
    in_valid = 1'b1; in_addr = 32'hA000_0000; in_data = 38'h1;
    tick();
    in_valid = 1'b0; err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (o_err_count !== (ErrLogEn ? 2'd1 : 2'd0)) begin miscompares++; $display("FAIL clear_coincident_count got %0d want %0d", o_err_count, ErrLogEn ? 1 : 0); end
    vectors++; if (o_err_addr !== (ErrLogEn ? 32'hA000_0000 : 32'h0)) begin miscompares++; $display("FAIL clear_coincident_addr got %h want %h", o_err_addr, ErrLogEn ? 32'hA000_0000 : 32'h0); end
    vectors++; if (o_err_valid !== ErrLogEn) begin miscompares++; $display("FAIL clear_coincident_valid got %0h want %0h", o_err_valid, ErrLogEn); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    logic [3:0]  decs  [4];
    logic        exp_stall, acc, drn;
    int          idx, oidx;
    addrs = '{32'h1000_0100, 32'h1100_0000, 32'h1000_0200, 32'h1200_0000};
    decs  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    idx = 0; oidx = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid  = (idx < 4);
      in_addr   = addrs[idx & 3];
      in_data   = {6'(idx), addrs[idx & 3]};
      in_stall  = (c >= 2 && c <= 4);
      exp_stall = (c >= 3 && c <= 5);
      vectors++; if (o_stall !== exp_stall) begin miscompares++; $display("FAIL bp_stall[c%0d] got %0h want %0h", c, o_stall, exp_stall); end
      if (c == 3 || c == 4) begin
        vectors++; if (o_addr !== addrs[1]) begin miscompares++; $display("FAIL bp_hold[c%0d] got %h want %h", c, o_addr, addrs[1]); end
      end
      acc = in_valid && !o_stall;
      drn = o_valid && !in_stall;
      if (drn) begin
        vectors++;
        if (oidx >= 4 || o_addr !== addrs[oidx & 3] || o_decode !== decs[oidx & 3] ||
            o_data !== {6'(oidx), addrs[oidx & 3]}) begin
          miscompares++;
          $display("FAIL bp_order[%0d] got a=%h dec=%b d=%h want a=%h dec=%b", oidx, o_addr,
                   o_decode, o_data, addrs[oidx & 3], decs[oidx & 3]);
        end
        oidx++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; in_stall = 1'b0;
    vectors++; if (oidx !== 4) begin miscompares++; $display("FAIL bp_delivered got %0d want 4", oidx); end
  endtask

  task automatic test_reset_full;
    in_stall = 1'b1;
    in_valid = 1'b1; in_addr = 32'h1000_0004; in_data = 38'h4;
    tick();
    in_addr = 32'h1000_0008; in_data = 38'h8;
    tick();
    in_valid = 1'b0;
    vectors++; if ({o_valid, o_stall} !== 2'b11) begin miscompares++; $display("FAIL full_state got v=%0h s=%0h want 1/1", o_valid, o_stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0; in_stall = 1'b0;
    vectors++; if ({o_valid, o_stall, o_decode} !== 6'b0) begin miscompares++; $display("FAIL reset_full got v=%0h s=%0h dec=%b want 0/0/0000", o_valid, o_stall, o_decode); end
    in_valid = 1'b1; in_addr = 32'h1000_0010; in_data = 38'h10;
    tick();
    in_valid = 1'b0;
    vectors++; if ({o_valid, o_decode, o_addr} !== {1'b1, 4'b0001, 32'h1000_0010}) begin miscompares++; $display("FAIL post_reset_req got v=%0h dec=%b a=%h want 1/0001/10000010", o_valid, o_decode, o_addr); end
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_replay got v=%0h want 0", o_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_decode();
    test_access_denied();
    test_saturation();
    test_back_to_back();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
